// File: rtl/ps2_led_tx.sv
// ps2_led_tx: host-side PS/2 transmitter that pushes the 0xED "set LEDs" command plus LED byte.
// Optional macro PS2_LED_ACK_WAIT_EN: wait for a 0xFA reply after each byte instead of a fixed gap.
module ps2_led_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       alpha_state,
    input  logic       turbo_state,
    input  logic [0:7] scancode,
    input  logic       trigger,
    output logic       busy,
    output logic       error
);
    localparam int unsigned MAX_A      = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned EDGE_W     = 4;
    localparam logic [7:0]  CMD_LED    = 8'hED;

    typedef enum logic [2:0] {IDLE, SEND_CMD, WAIT1, SEND_LED, WAIT2} state_t;
    typedef enum logic [1:0] {PH_INHIBIT, PH_START, PH_BITS} phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [EDGE_W-1:0]   edge_q, edge_d, edge_next;
    logic [7:0]          target_q, target_d, last_q, last_d;
    logic                clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic                busy_q, busy_d, error_q, error_d;
    logic [1:0]          clk_sync, data_sync;
    logic                clk_prev, ps2_fall;
    logic [7:0]          led_req, tx_byte;
    logic                parity_bit, timeout_hit, abort, byte_done, wait_done;

`ifndef PS2_LED_ACK_WAIT_EN
    logic unused_reply;
    assign unused_reply = ^{scancode, trigger};
`endif

    // Two-flop line synchronisers plus a history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign ps2_fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= PH_INHIBIT;
            cnt_q     <= '0;
            edge_q    <= '0;
            target_q  <= '0;
            last_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            target_q  <= target_d;
            last_q    <= last_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        target_d    = target_q;
        last_d      = last_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        error_d     = 1'b0;
        abort       = 1'b0;
        byte_done   = 1'b0;
        wait_done   = 1'b0;
        led_req     = {5'b0, alpha_state, 1'b0, turbo_state};
        tx_byte     = (state_q == SEND_LED) ? target_q : CMD_LED;
        parity_bit  = ~^tx_byte;
        cnt_inc     = cnt_q + CNT_W'(1);
        edge_next   = edge_q + EDGE_W'(1);
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            IDLE: begin
                if (led_req != last_q) begin
                    target_d  = led_req;
                    state_d   = SEND_CMD;
                    phase_d   = PH_INHIBIT;
                    cnt_d     = '0;
                    edge_d    = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                end
            end
            SEND_CMD, SEND_LED: begin
                case (phase_q)
                    PH_INHIBIT: begin
                        cnt_d = cnt_inc;
                        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                            phase_d   = PH_START;
                            data_oe_d = 1'b1;
                        end
                    end
                    PH_START: begin
                        phase_d  = PH_BITS;
                        clk_oe_d = 1'b0;
                        cnt_d    = '0;
                    end
                    default: begin
                        // Device clocks the frame; the host changes data right after each falling edge
                        if (ps2_fall) begin
                            cnt_d  = '0;
                            edge_d = edge_next;
                            if (edge_next <= EDGE_W'(8)) begin
                                data_oe_d = ~tx_byte[edge_q[2:0]];
                            end else if (edge_next == EDGE_W'(9)) begin
                                data_oe_d = ~parity_bit;
                            end else if (edge_next == EDGE_W'(10)) begin
                                data_oe_d = 1'b0;
                            end else if (data_sync[1]) begin
                                abort = 1'b1;
                            end else begin
                                byte_done = 1'b1;
                            end
                        end else if (timeout_hit) begin
                            abort = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                endcase
            end
            WAIT1, WAIT2: begin
`ifdef PS2_LED_ACK_WAIT_EN
                if (trigger) begin
                    if (scancode == 8'hFA) begin
                        wait_done = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`else
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    wait_done = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (byte_done) begin
            state_d = (state_q == SEND_CMD) ? WAIT1 : WAIT2;
            cnt_d   = '0;
        end

        if (wait_done) begin
            cnt_d = '0;
            if (state_q == WAIT1) begin
                state_d  = SEND_LED;
                phase_d  = PH_INHIBIT;
                edge_d   = '0;
                clk_oe_d = 1'b1;
            end else begin
                state_d = IDLE;
                last_d  = target_q;
            end
        end

        // Failures give up on this request: no retry until the LED inputs change again
        if (abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            error_d   = 1'b1;
            last_d    = target_q;
        end

        busy_d = (state_d != IDLE);
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign error       = error_q;
endmodule

// File: tb/tb_ps2_led_tx.sv
// tb_ps2_led_tx: bench for ps2_led_tx with an open-collector PS/2 keyboard model.
// Define PS2_LED_ACK_WAIT_EN to also cover the reply-wait variant.
`timescale 1ns/1ps
module tb_ps2_led_tx;
    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned GAP  = 100;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       alpha_state, turbo_state;
    logic [0:7] scancode;
    logic       trigger;
    logic       busy, error;

    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    bit         dev_silent, dev_abort;
    logic [7:0] dev_reply = 8'hFA;
    int         dev_pulse;
    logic [9:0] cap_q [$];

    int         n_checks, n_pass, err_pulses;
    logic [7:0] model_last;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_led_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .alpha_state(alpha_state),
        .turbo_state(turbo_state),
        .scancode   (scancode),
        .trigger    (trigger),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (error === 1'b1) err_pulses <= err_pulses + 1;

    // Keyboard side: clock out one host frame, capture {stop, parity, byte}, ack, then reply
    task automatic dev_xfer();
        logic [9:0] rec;
        rec = '0;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (dev_abort) begin
                dev_clk = 1'b1; dev_data = 1'b1; dev_pulse = 0;
                return;
            end
            if (k == 11) dev_data = 1'b0;
            dev_pulse = k;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) rec[4'(k - 1)] = ps2_data_in;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
        dev_pulse = 0;
        if (dev_abort) return;
        cap_q.push_back(rec);
        repeat (5) @(negedge clk);
        scancode = dev_reply;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    initial begin : device
        forever begin
            @(negedge clk);
            if (ps2_clk_oe === 1'b1) begin
                while (ps2_clk_oe === 1'b1) @(negedge clk);
                if (ps2_data_oe === 1'b1 && !dev_silent && !dev_abort) dev_xfer();
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Expected frame as the device sees it: data byte, odd parity, stop bit high
    function automatic logic [9:0] frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b};
    endfunction

    function automatic logic [7:0] led_of(input logic a, input logic t);
        return 8'(4 * int'(a) + int'(t));
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_req(input logic a, input logic t, input bit exp_seq,
                           input logic [7:0] exp_led, input string name);
        int e0;
        cap_q.delete();
        e0 = err_pulses;
        alpha_state = a;
        turbo_state = t;
        tick(3);
        check({name, " busy"}, 32'(busy), 32'(exp_seq));
        wait_idle(name, 6000);
        tick(2);
        check({name, " nbytes"}, 32'(cap_q.size()), exp_seq ? 32'd2 : 32'd0);
        if (exp_seq && cap_q.size() >= 2) begin
            check({name, " cmd"}, 32'(cap_q[0]), 32'(frame(8'hED)));
            check({name, " led"}, 32'(cap_q[1]), 32'(frame(exp_led)));
            model_last = exp_led;
        end
        check({name, " err"}, 32'(err_pulses - e0), 32'd0);
    endtask

    typedef struct {
        logic       a;
        logic       t;
        bit         seq;
        logic [7:0] led;
    } vec_t;

    initial begin : main
        vec_t vecs [6];
        int   n, e0;
        logic a, t;
        logic [7:0] led;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h04};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h04};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h05};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h01};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h01};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00};

        reset = 1'b1; alpha_state = 1'b0; turbo_state = 1'b0;
        scancode = 8'h00; trigger = 1'b0; model_last = 8'h00;
        tick(1);
        check("rst clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst error", 32'(error), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++)
            run_req(vecs[i].a, vecs[i].t, vecs[i].seq, vecs[i].led, $sformatf("vec%0d", i));

        // LED change mid-sequence is deferred to a second full sequence
        cap_q.delete();
        e0 = err_pulses;
        alpha_state = 1'b1;
        tick(200);
        turbo_state = 1'b1;
        n = 0;
        while ((cap_q.size() < 4 || busy !== 1'b0) && n < 12000) begin tick(); n++; end
        check("chain nbytes", 32'(cap_q.size()), 32'd4);
        if (cap_q.size() == 4) begin
            check("chain b0", 32'(cap_q[0]), 32'(frame(8'hED)));
            check("chain b1", 32'(cap_q[1]), 32'(frame(8'h04)));
            check("chain b2", 32'(cap_q[2]), 32'(frame(8'hED)));
            check("chain b3", 32'(cap_q[3]), 32'(frame(8'h05)));
        end
        check("chain err", 32'(err_pulses - e0), 32'd0);
        model_last = 8'h05;

        // Silent device: error exactly TMO cycles after the host releases the clock
        dev_silent = 1'b1;
        e0 = err_pulses;
        turbo_state = 1'b0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 50) begin tick(); n++; end
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < int'(INH) + 10) begin tick(); n++; end
        n = 0;
        while (error !== 1'b1 && n < int'(TMO) + 100) begin tick(); n++; end
        check("tmo latency", 32'(n), 32'(TMO));
        check("tmo clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("tmo data_oe", 32'(ps2_data_oe), 32'd0);
        check("tmo busy", 32'(busy), 32'd0);
        tick(1);
        check("tmo pulse width", 32'(error), 32'd0);
        tick(300);
        check("tmo no retry busy", 32'(busy), 32'd0);
        check("tmo err count", 32'(err_pulses - e0), 32'd1);
        model_last = 8'h04;
        dev_silent = 1'b0;

        // Reset in the middle of the 0xED frame, after falling edge 5
        alpha_state = 1'b0;
        n = 0;
        while (!(dev_pulse == 5 && dev_clk == 1'b0) && n < 2000) begin tick(); n++; end
        tick(4);
        check("edge5 data_oe", 32'(ps2_data_oe), 32'd1);
        dev_abort = 1'b1;
        reset = 1'b1;
        tick(1);
        check("midrst clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst data_oe", 32'(ps2_data_oe), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst error", 32'(error), 32'd0);
        reset = 1'b0;
        model_last = 8'h00;
        tick(100);
        dev_abort = 1'b0;
        tick(10);
        check("postrst idle", 32'(busy), 32'd0);
        run_req(1'b1, 1'b0, 1'b1, 8'h04, "postrst");

        // Random requests against the last-sent model
        for (int i = 0; i < 6; i++) begin
            a = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            led = led_of(a, t);
            run_req(a, t, led != model_last, led, $sformatf("rand%0d", i));
        end

`ifdef PS2_LED_ACK_WAIT_EN
        // Device rejects the command byte: LED byte must never go out
        cap_q.delete();
        e0 = err_pulses;
        dev_reply = 8'hFE;
        a = ~model_last[2];
        alpha_state = a;
        turbo_state = 1'b0;
        n = 0;
        while (error !== 1'b1 && n < 3000) begin tick(); n++; end
        check("nak error", 32'(error), 32'd1);
        tick(300);
        check("nak nbytes", 32'(cap_q.size()), 32'd1);
        check("nak busy", 32'(busy), 32'd0);
        check("nak err count", 32'(err_pulses - e0), 32'd1);
        dev_reply = 8'hFA;
        model_last = led_of(a, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
